// File: rtl/op_imm_issue_stage.sv
// OP-IMM decode/issue stage: captures instruction + rs1 value, presents a decoded op to the ALU.
// Define OP_IMM_ISSUE_SKID_EN for a two-entry skid buffer with registered instruction_ready.
module op_imm_issue_stage #(
  parameter logic [6:0]  OPCODE_OP_IMM   = 7'b0010011,
  parameter int unsigned ERR_COUNT_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       instruction_valid,
  input  logic [31:0]                instruction,
  output logic                       instruction_ready,
  output logic [4:0]                 rs1_address,
  input  logic [31:0]                rs1_value,
  output logic                       issue_valid,
  input  logic                       issue_ready,
  output logic [2:0]                 subfunction_3,
  output logic [31:0]                immediate,
  output logic [31:0]                input_register_value,
  output logic [4:0]                 destination_register,
  output logic                       decoding_error,
  output logic [ERR_COUNT_WIDTH-1:0] error_count
);

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned F3_W   = 3;
  localparam int unsigned F7_W   = 7;

  typedef struct packed {
    logic [F3_W-1:0]   funct3;
    logic [XLEN-1:0]   imm;
    logic [XLEN-1:0]   rs1_val;
    logic [REG_AW-1:0] rd;
    logic              err;
  } entry_t;

`ifdef OP_IMM_ISSUE_SKID_EN
  typedef enum logic [1:0] {S_EMPTY = 2'd0, S_ONE = 2'd1, S_TWO = 2'd2} state_e;
`else
  typedef enum logic [0:0] {S_EMPTY = 1'b0, S_ONE = 1'b1} state_e;
`endif

  state_e                     state_q, state_d;
  entry_t                     head_q, head_d;
  entry_t                     dec;
  logic [ERR_COUNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
  logic [F7_W-1:0]            funct7;
  logic                       accept;
  logic                       issue;

  assign rs1_address = instruction[19:15];
  assign funct7      = instruction[31:25];
  assign accept      = instruction_valid && instruction_ready;
  assign issue_valid = (state_q != S_EMPTY);
  assign issue       = issue_valid && issue_ready;

  // Field extraction and legality check for the incoming word
  always_comb begin
    dec         = '0;
    dec.funct3  = instruction[14:12];
    dec.imm     = {{20{instruction[31]}}, instruction[31:20]};
    dec.rs1_val = rs1_value;
    dec.rd      = instruction[11:7];
    dec.err     = (instruction[6:0] != OPCODE_OP_IMM)
               || ((dec.funct3 == 3'b001) && (funct7 != 7'b0000000))
               || ((dec.funct3 == 3'b101) && (funct7 != 7'b0000000)
                                          && (funct7 != 7'b0100000));
  end

  // Saturating count of accepted illegal words
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (accept && dec.err && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + ERR_COUNT_WIDTH'(1);
    end
  end

`ifdef OP_IMM_ISSUE_SKID_EN
  entry_t tail_q, tail_d;
  logic   ready_q, ready_d;

  assign instruction_ready = ready_q;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case (state_q)
      S_EMPTY: begin
        if (accept) begin
          head_d  = dec;
          state_d = S_ONE;
        end
      end
      S_ONE: begin
        if (issue) begin
          if (accept) head_d = dec;
          else        state_d = S_EMPTY;
        end else if (accept) begin
          tail_d  = dec;
          state_d = S_TWO;
        end
      end
      S_TWO: begin
        if (issue) begin
          head_d  = tail_q;
          state_d = S_ONE;
        end
      end
      default: state_d = S_EMPTY;
    endcase
    ready_d = (state_d != S_TWO);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tail_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      tail_q  <= tail_d;
      ready_q <= ready_d;
    end
  end
`else
  logic rst_done_q;

  // Ready is held low until the first edge after reset release
  assign instruction_ready = rst_done_q && (!issue_valid || issue_ready);

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    case (state_q)
      S_EMPTY: begin
        if (accept) begin
          head_d  = dec;
          state_d = S_ONE;
        end
      end
      S_ONE: begin
        if (issue) begin
          if (accept) head_d = dec;
          else        state_d = S_EMPTY;
        end
      end
      default: state_d = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_done_q <= 1'b0;
    else          rst_done_q <= 1'b1;
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_EMPTY;
      head_q    <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      head_q    <= head_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign subfunction_3        = head_q.funct3;
  assign immediate            = head_q.imm;
  assign input_register_value = head_q.rs1_val;
  assign destination_register = head_q.rd;
  assign decoding_error       = head_q.err;
  assign error_count          = err_cnt_q;

endmodule
